uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single kernel UART transmit line between two byte requesters: the host control-register path (s0) and the m00_axi DMA readback path (s1).
- Round-robin arbitration, one byte per grant.
- Serializes each granted byte as an 8N1 frame, LSB first.
- Reports busy status and a running byte count to the s_axi_control register file.

Parameters:
CLKS_PER_BIT, 868, ap_clk cycles per UART bit (100 MHz / 115200); must be >= 2
STOP_BITS, 1, number of stop bits; legal values 1 or 2
C_CNT_WIDTH, 32, width of the byte_count status counter

Ports:
ap_clk  in  1  kernel clock
ap_rst_n  in  1  asynchronous active-low reset
s0_valid  in  1  requester 0 (control path) byte valid
s0_ready  out  1  requester 0 byte accepted
s0_data  in  8  requester 0 byte
s1_valid  in  1  requester 1 (DMA path) byte valid
s1_ready  out  1  requester 1 byte accepted
s1_data  in  8  requester 1 byte
uart_tx  out  1  serial output, idle high
tx_busy  out  1  high while a frame is in progress (any state other than IDLE)
grant_id  out  1  requester owning the current or most recent frame
byte_count  out  C_CNT_WIDTH  number of frames completed since reset

Behaviour:
- Clock and reset: single clock, ap_clk. ap_rst_n is asynchronous assert, synchronous deassert (synchronizer external).
- Reset values:
  - uart_tx=1; s0_ready=0, s1_ready=0; tx_busy=0; grant_id=0; byte_count=0.
  - Internal last_grant=1, so s0 wins the first tie.
- FSM states: IDLE, START, DATA, STOP (PARITY added by the optional feature).
- IDLE grant selection:
  - Only s0_valid high -> grant s0.
  - Only s1_valid high -> grant s1.
  - Both high -> grant the requester != last_grant.
- Ready and handshake:
  - sN_ready is combinational: asserted only in IDLE, only for the granted requester, only while its valid is high.
  - Never both readys high in the same cycle.
  - Handshake on cycle N (valid && ready) latches data into the shift register and updates grant_id and last_grant.
  - FSM enters START at N+1; uart_tx=0 from N+1.
- Bit timing:
  - Baud counter loads CLKS_PER_BIT-1 on entry to every bit and decrements to 0; each bit lasts exactly CLKS_PER_BIT cycles.
  - A 3-bit index counts DATA bits 0..7, LSB first, shifting right.
  - STOP drives 1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame end:
  - On the last cycle of STOP: byte_count increments (wraps modulo 2^C_CNT_WIDTH) and the FSM returns to IDLE.
  - Minimum inter-frame gap is 1 idle cycle: a new handshake can occur on the first IDLE cycle.
- Frame length: 1+8+STOP_BITS bits. tx_busy is high from N+1 through the last STOP cycle.
- Valid without ready: a requester must hold valid/data until ready. Dropping valid while not granted is tolerated; no byte is taken.
- Data changing while valid is high: ignored except on the handshake cycle.
- Reset mid-frame: uart_tx returns to 1 immediately (asynchronous). The frame is aborted and not counted; the aborted byte is lost.
- uart_tx is driven from a register; no combinational path from any input to uart_tx.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - Transmits the even-parity bit, computed as the XOR of the 8 data bits at handshake.
  - Frame length becomes 1+8+1+STOP_BITS bits.
- Undefined: no PARITY state; plain 8N1 or 8N2.

Decomposition:
- Package uart_pkg:
  - FSM state enum (tx_state_t).
  - UART_DATA_BITS=8.
  - Default CLKS_PER_BIT constant.
  - Grant id typedef.
- Sub-module uart_tx_serializer: baud counter, shift register, bit index and FSM, with a start/data/done interface.
- The top module keeps the round-robin arbiter, ready generation, grant_id and byte_count.

Test Plan:
- Single byte, CLKS_PER_BIT=4, STOP_BITS=1: s0 sends 0xA5. Required response:
  - uart_tx = 0, then 1,0,1,0,0,1,0,1, then 1; each bit held 4 cycles.
  - Start bit begins the cycle after the handshake.
  - tx_busy high for 40 cycles; byte_count=1; grant_id=0.
- Tie after reset: s0=0x11 and s1=0x22 valid simultaneously and held. Required response:
  - Frames go out s0, s1, s0, s1 (grant_id 0,1,0,1).
  - 1-cycle idle gap between frames; never both readys high.
- Single requester: s1 alone streams 3 bytes back-to-back. Required response:
  - s1 granted every time; the round-robin pointer does not starve it.
  - byte_count=3.
- Reset mid-frame: assert ap_rst_n low during DATA bit 3. Required response:
  - uart_tx=1 in the same cycle; byte_count=0; all readys 0.
  - After release, the next frame is fully intact.
- Counter wrap: C_CNT_WIDTH=4, send 17 bytes. Required response: byte_count reads 15 after the 15th frame, 0 after the 16th, 1 after the 17th.
- UART_TX_PARITY_EN defined: send 0xA5, then 0x01. Required response:
  - Parity bit 0 for 0xA5 and 1 for 0x01, placed after data bit 7.
  - Frame length 11 bits.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the kernel UART transmit path: the
// serializer FSM state encoding, the data width of one UART character, the
// default bit period and the requester id type used by the arbiter.
//
// Optional build macro: UART_TX_PARITY_EN adds the PARITY state.
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS       = 8;
    // 100 MHz kernel clock at 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef logic grant_id_t;
    localparam grant_id_t GRANT_S0 = 1'b0;
    localparam grant_id_t GRANT_S1 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        ST_PARITY = 3'd4
`endif
    } tx_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// ----------------------------------------------------------------------------
// uart_tx_serializer
// Turns one byte into an 8N1 / 8N2 frame (optionally with an even-parity bit),
// LSB first, on a registered serial output.
//
// Ports:
//   clk, rst_n : kernel clock, asynchronous active-low reset
//   start      : byte accepted this cycle (only honoured while idle)
//   data       : byte to send, captured on start
//   idle       : FSM is in IDLE and can accept a byte
//   done       : pulse on the last cycle of the final stop bit
//   tx         : serial line, idle high
//
// Optional build macro: UART_TX_PARITY_EN inserts a PARITY bit after data
// bit 7.
// ----------------------------------------------------------------------------
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [UART_DATA_BITS-1:0] data,
    output logic                      idle,
    output logic                      done,
    output logic                      tx
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W  = $clog2(UART_DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

    tx_state_t                 state, state_next;
    logic [BAUD_W-1:0]         baud, baud_next;
    logic [IDX_W-1:0]          bit_idx, bit_idx_next;
    logic                      stop_idx, stop_idx_next;
    logic                      tx_next;
    logic [UART_DATA_BITS-1:0] shift, shift_next;
    logic                      bit_end;
    logic                      stop_last;
`ifdef UART_TX_PARITY_EN
    logic                      parity, parity_next;
`endif

    assign bit_end   = (baud == '0);
    assign stop_last = (STOP_BITS == 1) || stop_idx;
    assign idle      = (state == ST_IDLE);

    // tx_next is the value of the bit being entered, so the line is driven
    // straight from a flop and changes on the same edge as the state.
    always_comb begin
        state_next    = state;
        baud_next     = (state != ST_IDLE && !bit_end) ? baud - BAUD_ONE : baud;
        bit_idx_next  = bit_idx;
        stop_idx_next = stop_idx;
        tx_next       = tx;
        shift_next    = shift;
        done          = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next   = parity;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next  = ST_START;
                    baud_next   = BAUD_LOAD;
                    shift_next  = data;
                    tx_next     = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^data;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_next   = ST_DATA;
                    baud_next    = BAUD_LOAD;
                    bit_idx_next = '0;
                    tx_next      = shift[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_next = BAUD_LOAD;
                    if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_next    = ST_PARITY;
                        tx_next       = parity;
`else
                        state_next    = ST_STOP;
                        stop_idx_next = 1'b0;
                        tx_next       = 1'b1;
`endif
                    end else begin
                        // shift[0] always holds the bit currently on the line
                        bit_idx_next = bit_idx + IDX_ONE;
                        shift_next   = shift >> 1;
                        tx_next      = shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_next    = ST_STOP;
                    baud_next     = BAUD_LOAD;
                    stop_idx_next = 1'b0;
                    tx_next       = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_last) begin
                        state_next = ST_IDLE;
                        done       = 1'b1;
                    end else begin
                        stop_idx_next = 1'b1;
                        baud_next     = BAUD_LOAD;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_next;
            baud     <= baud_next;
            bit_idx  <= bit_idx_next;
            stop_idx <= stop_idx_next;
            tx       <= tx_next;
        end
    end

    // Payload registers carry no reset: they are always loaded before use.
    always_ff @(posedge clk) begin
        shift  <= shift_next;
`ifdef UART_TX_PARITY_EN
        parity <= parity_next;
`endif
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares the kernel UART transmit line between the control-register path (s0)
// and the DMA readback path (s1). Round-robin, one byte per grant; each
// granted byte is sent by uart_tx_serializer.
//
// Ports:
//   ap_clk, ap_rst_n       : kernel clock, asynchronous active-low reset
//   s0_valid/ready/data    : requester 0 byte handshake
//   s1_valid/ready/data    : requester 1 byte handshake
//   uart_tx                : serial output, idle high, driven from a flop
//   tx_busy                : a frame is in progress
//   grant_id               : requester owning the current / most recent frame
//   byte_count             : frames completed since reset (wraps)
//
// Optional build macro: UART_TX_PARITY_EN adds an even-parity bit per frame.
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1,
    parameter int C_CNT_WIDTH  = 32
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      s0_valid,
    output logic                      s0_ready,
    input  logic [UART_DATA_BITS-1:0] s0_data,
    input  logic                      s1_valid,
    output logic                      s1_ready,
    input  logic [UART_DATA_BITS-1:0] s1_data,
    output logic                      uart_tx,
    output logic                      tx_busy,
    output logic                      grant_id,
    output logic [C_CNT_WIDTH-1:0]    byte_count
);

    grant_id_t                 last_grant;
    grant_id_t                 sel;
    logic                      idle;
    logic                      done;
    logic                      start;
    logic                      accept;
    logic [UART_DATA_BITS-1:0] sel_data;

    // On a tie the requester that did not own the previous frame wins; a lone
    // requester always wins, so neither side can starve.
    always_comb begin
        if (s0_valid && s1_valid) begin
            sel = ~last_grant;
        end else if (s1_valid) begin
            sel = GRANT_S1;
        end else begin
            sel = GRANT_S0;
        end
    end

    // Readys are held low while reset is asserted even though the FSM is idle.
    assign accept   = idle && ap_rst_n;
    assign s0_ready = accept && s0_valid && (sel == GRANT_S0);
    assign s1_ready = accept && s1_valid && (sel == GRANT_S1);
    assign start    = s0_ready || s1_ready;
    assign sel_data = (sel == GRANT_S1) ? s1_data : s0_data;
    assign tx_busy  = ~idle;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            grant_id   <= GRANT_S0;
            last_grant <= GRANT_S1;
            byte_count <= '0;
        end else begin
            if (start) begin
                grant_id   <= sel;
                last_grant <= sel;
            end
            if (done) begin
                byte_count <= byte_count + C_CNT_WIDTH'(1);
            end
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .STOP_BITS    (STOP_BITS)
    ) u_serializer (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .start (start),
        .data  (sel_data),
        .idle  (idle),
        .done  (done),
        .tx    (uart_tx)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int CPB   = 4;
    localparam int STOP  = 1;
    localparam int CNT_W = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_BITS = 1 + 8 + PAR_BITS + STOP;
    localparam int FRAME_CYC  = FRAME_BITS * CPB;
    localparam int CNT_MOD    = 1 << CNT_W;

    logic             ap_clk   = 1'b0;
    logic             ap_rst_n = 1'b0;
    logic             s0_valid = 1'b0;
    logic [7:0]       s0_data  = 8'h00;
    logic             s1_valid = 1'b0;
    logic [7:0]       s1_data  = 8'h00;
    logic             s0_ready, s1_ready;
    logic             uart_tx, tx_busy, grant_id;
    logic [CNT_W-1:0] byte_count;

    int tests      = 0;
    int fails      = 0;
    int both_ready = 0;
    int exp_cnt    = 0;

    always #5 ap_clk = ~ap_clk;

    uart_tx_arbiter #(
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (STOP),
        .C_CNT_WIDTH  (CNT_W)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .s0_valid   (s0_valid),
        .s0_ready   (s0_ready),
        .s0_data    (s0_data),
        .s1_valid   (s1_valid),
        .s1_ready   (s1_ready),
        .s1_data    (s1_data),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .byte_count (byte_count)
    );

    // Both readys must never be high together.
    always begin
        @(negedge ap_clk);
        #2;
        if (s0_ready === 1'b1 && s1_ready === 1'b1) both_ready++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       gid;
        logic [7:0] exp_byte;
        logic       par;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Line level of each transmitted bit, index 0 = start bit.
    function automatic logic [11:0] frame_of(input logic [7:0] d, input logic p);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (PAR_BITS == 1) f[9] = p;
        return f;
    endfunction

    // Call just after driving at a negedge; returns at the handshake cycle.
    task automatic wait_hs(output bit ok, output logic who, output int waited);
        ok = 0; who = 0; waited = 0;
        #1;
        while (!ok && waited < 4 * FRAME_CYC) begin
            if (s0_ready || s1_ready) begin
                ok  = 1;
                who = s1_ready;
            end else begin
                @(negedge ap_clk);
                #1;
                waited++;
            end
        end
    endtask

    // Call in the handshake cycle. Drives the given requester values on the
    // first frame cycle, then samples every cycle of the frame.
    task automatic capture_frame(input string nm, input logic [7:0] d, input logic p,
                                 input logic gid, input logic nv0, input logic [7:0] nd0,
                                 input logic nv1, input logic [7:0] nd1);
        logic [11:0] got;
        int          busy_n;
        int          unstable;
        got = '1; busy_n = 0; unstable = 0;
        @(posedge ap_clk);
        for (int b = 0; b < FRAME_BITS; b++) begin
            for (int k = 0; k < CPB; k++) begin
                @(negedge ap_clk);
                if (b == 0 && k == 0) begin
                    s0_valid = nv0; s0_data = nd0;
                    s1_valid = nv1; s1_data = nd1;
                end
                #1;
                if (k == 0) got[b] = uart_tx;
                else if (uart_tx !== got[b]) unstable++;
                if (tx_busy === 1'b1) busy_n++;
            end
        end
        check({nm, "_frame"}, 32'(got), 32'(frame_of(d, p)));
        check({nm, "_bit_hold"}, unstable, 0);
        check({nm, "_busy_cycles"}, busy_n, FRAME_CYC);
        check({nm, "_grant_id"}, 32'(grant_id), 32'(gid));
    endtask

    task automatic idle_check(input string nm, input int cnt);
        @(negedge ap_clk);
        #1;
        check({nm, "_idle_busy"}, 32'(tx_busy), 0);
        check({nm, "_idle_tx"}, 32'(uart_tx), 1);
        check({nm, "_count"}, 32'(byte_count), cnt % CNT_MOD);
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        s0_valid = 0; s1_valid = 0; ap_rst_n = 0;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1;
        exp_cnt  = 0;
    endtask

    initial begin
        vec_t        vecs[8];
        bit          ok;
        logic        who;
        int          waited;
        logic [7:0]  d;
        int          m_rem, m_cnt, err_tx, err_busy, err_rdy, err_gid, err_cnt, m_frames;
        logic [11:0] m_frame;
        logic        m_last, m_gid, hs0, hs1, exp_tx, exp_r0, exp_r1;

        // {s0_valid, s0_data, s1_valid, s1_data, winner, byte, even parity}
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b1, 8'h3C, 1'b0};
        vecs[2] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 8'h11, 1'b0};
        vecs[3] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 8'h22, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 8'h07, 1'b1, 8'h07, 1'b1};
        vecs[5] = '{1'b1, 8'h00, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1};
        vecs[7] = '{1'b1, 8'h5A, 1'b1, 8'hC3, 1'b1, 8'hC3, 1'b0};

        // Reset values, with both valids raised during reset.
        s0_valid = 1; s1_valid = 1;
        repeat (3) @(negedge ap_clk);
        #1;
        check("rst_uart_tx", 32'(uart_tx), 1);
        check("rst_s0_ready", 32'(s0_ready), 0);
        check("rst_s1_ready", 32'(s1_ready), 0);
        check("rst_tx_busy", 32'(tx_busy), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_byte_count", 32'(byte_count), 0);
        s0_valid = 0; s1_valid = 0;
        @(negedge ap_clk);
        ap_rst_n = 1;

        // Table vectors, one frame each, in sequence from reset.
        foreach (vecs[i]) begin
            @(negedge ap_clk);
            s0_valid = vecs[i].v0; s0_data = vecs[i].d0;
            s1_valid = vecs[i].v1; s1_data = vecs[i].d1;
            wait_hs(ok, who, waited);
            check($sformatf("vec%0d_handshake", i), 32'(ok), 1);
            check($sformatf("vec%0d_winner", i), 32'(who), 32'(vecs[i].gid));
            capture_frame($sformatf("vec%0d", i), vecs[i].exp_byte, vecs[i].par,
                          vecs[i].gid, 1'b0, 8'h00, 1'b0, 8'h00);
            exp_cnt++;
            idle_check($sformatf("vec%0d", i), exp_cnt);
        end

        // Tie held after reset: s0, s1, s0, s1 with one idle cycle between.
        do_reset();
        @(negedge ap_clk);
        s0_valid = 1; s0_data = 8'h11; s1_valid = 1; s1_data = 8'h22;
        for (int f = 0; f < 4; f++) begin
            wait_hs(ok, who, waited);
            check($sformatf("tie%0d_handshake", f), 32'(ok), 1);
            check($sformatf("tie%0d_winner", f), 32'(who), f % 2);
            if (f > 0) check($sformatf("tie%0d_gap_wait", f), waited, 0);
            capture_frame($sformatf("tie%0d", f), (f % 2 == 1) ? 8'h22 : 8'h11, 1'b0,
                          logic'(f % 2), f < 3, 8'h11, f < 3, 8'h22);
            exp_cnt++;
            idle_check($sformatf("tie%0d", f), exp_cnt);
        end

        // s1 alone streams three bytes back to back.
        do_reset();
        @(negedge ap_clk);
        s1_valid = 1; s1_data = 8'h5A;
        for (int f = 0; f < 3; f++) begin
            wait_hs(ok, who, waited);
            check($sformatf("stream%0d_winner", f), 32'(who), 1);
            if (f > 0) check($sformatf("stream%0d_gap_wait", f), waited, 0);
            capture_frame($sformatf("stream%0d", f), (f == 0) ? 8'h5A : (f == 1) ? 8'hC3 : 8'h0F,
                          (f == 0) ? 1'b0 : (f == 1) ? 1'b0 : 1'b0, 1'b1,
                          1'b0, 8'h00, f < 2, (f == 0) ? 8'hC3 : 8'h0F);
            exp_cnt++;
            idle_check($sformatf("stream%0d", f), exp_cnt);
        end

        // Reset in the middle of data bit 3, then an intact frame.
        @(negedge ap_clk);
        s0_valid = 1; s0_data = 8'h37;
        wait_hs(ok, who, waited);
        check("midrst_winner", 32'(who), 0);
        @(posedge ap_clk);
        for (int c = 0; c < 18; c++) begin
            @(negedge ap_clk);
            if (c == 0) s0_valid = 0;
        end
        #1;
        check("midrst_bit3_low", 32'(uart_tx), 0);
        s1_valid = 1; s1_data = 8'h96;
        ap_rst_n = 0;
        #1;
        check("midrst_uart_tx", 32'(uart_tx), 1);
        check("midrst_tx_busy", 32'(tx_busy), 0);
        check("midrst_byte_count", 32'(byte_count), 0);
        check("midrst_s0_ready", 32'(s0_ready), 0);
        check("midrst_s1_ready", 32'(s1_ready), 0);
        check("midrst_grant_id", 32'(grant_id), 0);
        @(negedge ap_clk);
        ap_rst_n = 1;
        exp_cnt  = 0;
        wait_hs(ok, who, waited);
        check("postrst_winner", 32'(who), 1);
        capture_frame("postrst", 8'h96, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        exp_cnt++;
        idle_check("postrst", exp_cnt);

        // Counter wrap through 17 frames on a 4-bit counter.
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            @(negedge ap_clk);
            d = 8'(i * 37);
            s0_valid = 1; s0_data = d;
            wait_hs(ok, who, waited);
            capture_frame($sformatf("wrap%0d", i), d, ^d, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
            exp_cnt++;
            idle_check($sformatf("wrap%0d", i), exp_cnt);
        end

        // Random traffic against a cycle-level reference model.
        do_reset();
        m_rem = 0; m_cnt = 0; m_last = 1; m_gid = 0; m_frame = '1; m_frames = 0;
        err_tx = 0; err_busy = 0; err_rdy = 0; err_gid = 0; err_cnt = 0;
        hs0 = 0; hs1 = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge ap_clk);
            if (hs0) s0_valid = 0;
            if (hs1) s1_valid = 0;
            if (s0_valid) begin
                if ($urandom_range(0, 7) == 0) s0_data = 8'($urandom);
                if ($urandom_range(0, 15) == 0) s0_valid = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                s0_valid = 1; s0_data = 8'($urandom);
            end
            if (s1_valid) begin
                if ($urandom_range(0, 7) == 0) s1_data = 8'($urandom);
                if ($urandom_range(0, 15) == 0) s1_valid = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                s1_valid = 1; s1_data = 8'($urandom);
            end
            #1;
            exp_tx = (m_rem > 0) ? m_frame[(FRAME_CYC - m_rem) / CPB] : 1'b1;
            exp_r0 = 0; exp_r1 = 0;
            if (m_rem == 0) begin
                if (s0_valid && s1_valid) begin
                    if (m_last) exp_r0 = 1; else exp_r1 = 1;
                end else if (s0_valid) exp_r0 = 1;
                else if (s1_valid) exp_r1 = 1;
            end
            if (uart_tx !== exp_tx) err_tx++;
            if (tx_busy !== (m_rem > 0)) err_busy++;
            if (s0_ready !== exp_r0 || s1_ready !== exp_r1) err_rdy++;
            if (grant_id !== m_gid) err_gid++;
            if (32'(byte_count) !== (m_cnt % CNT_MOD)) err_cnt++;
            hs0 = exp_r0; hs1 = exp_r1;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) m_cnt++;
            end else if (exp_r0 || exp_r1) begin
                d       = exp_r1 ? s1_data : s0_data;
                m_rem   = FRAME_CYC;
                m_gid   = exp_r1;
                m_last  = exp_r1;
                m_frame = frame_of(d, ^d);
                m_frames++;
            end
        end
        check("rand_uart_tx_errors", err_tx, 0);
        check("rand_tx_busy_errors", err_busy, 0);
        check("rand_ready_errors", err_rdy, 0);
        check("rand_grant_id_errors", err_gid, 0);
        check("rand_byte_count_errors", err_cnt, 0);
        @(negedge ap_clk);
        s0_valid = 0; s1_valid = 0;

        check("both_ready_cycles", both_ready, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
